// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared widths, FSM states and 7-segment patterns for the BCD converter
package fib_pkg;

   localparam int BIN_W      = 16;
   localparam int BCD_DIGITS = 5;

   typedef enum logic [1:0] {BCD_IDLE, BCD_SHIFT, BCD_HOLD} bcd_state_t;
   typedef logic [3:0] bcd_digit_t;

   // Segment order {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic logic [6:0] seg_decode(input bcd_digit_t d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble nibble correction: add 3 when the digit is 5 or more
module bcd_digit_adj
   import fib_pkg::*;
(
   input  bcd_digit_t digit_in,
   output bcd_digit_t digit_out
);

   assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/fib_bcd_converter.sv
// rtl/fib_bcd_converter.sv - sequential 16-bit binary to 5-digit BCD converter; FIB_BCD_SEVENSEG_EN adds seg_out
module fib_bcd_converter
   import fib_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [BIN_W-1:0]        in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [4*BCD_DIGITS-1:0] bcd_out,
   output logic [2:0]              num_digits
`ifdef FIB_BCD_SEVENSEG_EN
   ,
   output logic [7*BCD_DIGITS-1:0] seg_out
`endif
);

   bcd_state_t              state, state_next;
   logic [BIN_W-1:0]        bin_sr;
   logic [4*BCD_DIGITS-1:0] bcd_acc, bcd_adj, bcd_shifted;
   logic [3:0]              bit_cnt;
   logic [2:0]              nd_next;

   for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (bcd_acc[4*g +: 4]),
         .digit_out (bcd_adj[4*g +: 4])
      );
   end

   assign bcd_shifted = {bcd_adj[4*BCD_DIGITS-2:0], bin_sr[BIN_W-1]};

   // Digit count of the value produced by the final shift
   always_comb begin
      nd_next = 3'd1;
      for (int k = 1; k < BCD_DIGITS; k++) begin
         if (bcd_shifted[4*k +: 4] != 4'd0) nd_next = 3'(k + 1);
      end
   end

   assign in_ready  = (state == BCD_IDLE);
   assign out_valid = (state == BCD_HOLD);

   always_ff @(posedge clk) begin
      if (reset) state <= BCD_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         BCD_IDLE:  if (in_valid)         state_next = BCD_SHIFT;
         BCD_SHIFT: if (bit_cnt == 4'd0)  state_next = BCD_HOLD;
         BCD_HOLD:  if (out_ready)        state_next = BCD_IDLE;
         default:                         state_next = BCD_IDLE;
      endcase
   end

`ifdef FIB_BCD_SEVENSEG_EN
   logic [7*BCD_DIGITS-1:0] seg_next;

   always_comb begin
      seg_next = '0;
      for (int k = 0; k < BCD_DIGITS; k++) begin
         if (k == 0 || 3'(k) < nd_next)
            seg_next[7*k +: 7] = seg_decode(bcd_shifted[4*k +: 4]);
         else
            seg_next[7*k +: 7] = SEG_BLANK;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         seg_out <= {{(BCD_DIGITS-1){SEG_BLANK}}, SEG_0};
      else if (state == BCD_SHIFT && bit_cnt == 4'd0)
         seg_out <= seg_next;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_sr     <= '0;
         bcd_acc    <= '0;
         bit_cnt    <= '0;
         bcd_out    <= '0;
         num_digits <= 3'd1;
      end else begin
         case (state)
            BCD_IDLE: begin
               if (in_valid) begin
                  bin_sr  <= in_data;
                  bcd_acc <= '0;
                  bit_cnt <= 4'(BIN_W - 1);
               end
            end
            BCD_SHIFT: begin
               bcd_acc <= bcd_shifted;
               bin_sr  <= {bin_sr[BIN_W-2:0], 1'b0};
               bit_cnt <= bit_cnt - 4'd1;
               if (bit_cnt == 4'd0) begin
                  bcd_out    <= bcd_shifted;
                  num_digits <= nd_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_bcd_converter.sv
// tb/tb_fib_bcd_converter.sv - directed self-checking bench for fib_bcd_converter
module tb_fib_bcd_converter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [19:0] bcd_out;
   logic [2:0]  num_digits;
`ifdef FIB_BCD_SEVENSEG_EN
   logic [34:0] seg_out;
`endif

   int n_cmp = 0;
   int n_err = 0;

   fib_bcd_converter dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .bcd_out    (bcd_out),
      .num_digits (num_digits)
`ifdef FIB_BCD_SEVENSEG_EN
      ,
      .seg_out    (seg_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   // Accepts val and stops at the first HOLD cycle; the caller releases it
   task automatic do_conv(input string tag, input logic [15:0] val,
                          input logic [19:0] eb, input logic [2:0] en);
      bit ok;
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      in_data  = val;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_valid(40, ok);
      chk({tag, "_done"}, ok, 1'b1);
      chk({tag, "_bcd"}, bcd_out, eb);
      chk({tag, "_nd"}, num_digits, en);
   endtask

   initial begin
      bit early;
      bit stable;
      bit ok;

      step();
      step();
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_bcd", bcd_out, 20'h00000);
      chk("rst_nd", num_digits, 3'd1);
`ifdef FIB_BCD_SEVENSEG_EN
      chk("rst_seg", seg_out, {28'h0, 7'b0111111});
`endif
      reset = 1'b0;
      step();
      chk("idle_in_ready", in_ready, 1'b1);

      // F24 with exact latency
      out_ready = 1'b1;
      in_data   = 16'd46368;
      in_valid  = 1'b1;
      step();
      in_valid  = 1'b0;
      chk("f24_busy", in_ready, 1'b0);
      early = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         if (out_valid) early = 1'b1;
         step();
      end
      if (out_valid) early = 1'b1;
      chk("f24_no_early_valid", early, 1'b0);
      step();
      chk("f24_valid_at_16", out_valid, 1'b1);
      chk("f24_in_ready_hold", in_ready, 1'b0);
      chk("f24_bcd", bcd_out, 20'h46368);
      chk("f24_nd", num_digits, 3'd5);
      step();
      chk("f24_released", out_valid, 1'b0);
      chk("f24_in_ready_after", in_ready, 1'b1);

      // Extremes
      do_conv("zero", 16'd0, 20'h00000, 3'd1);
`ifdef FIB_BCD_SEVENSEG_EN
      chk("zero_seg", seg_out, {28'h0, 7'b0111111});
`endif
      step();
      do_conv("max", 16'd65535, 20'h65535, 3'd5);
`ifdef FIB_BCD_SEVENSEG_EN
      chk("max_seg", seg_out, {7'h7D, 7'h6D, 7'h6D, 7'h4F, 7'h6D});
`endif
      step();

      // Back-pressure: result held while 144 is offered and ignored
      out_ready = 1'b0;
      in_data   = 16'd89;
      in_valid  = 1'b1;
      step();
      in_valid  = 1'b0;
      wait_valid(40, ok);
      chk("bp_done", ok, 1'b1);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data  = 16'd144;
         in_valid = i[0];
         if (!out_valid || in_ready || bcd_out !== 20'h00089 || num_digits !== 3'd2)
            stable = 1'b0;
         step();
      end
      in_valid = 1'b0;
      chk("bp_stable", stable, 1'b1);
      chk("bp_bcd", bcd_out, 20'h00089);
      out_ready = 1'b1;
      step();
      chk("bp_released", out_valid, 1'b0);
      chk("bp_idle", in_ready, 1'b1);
      do_conv("after_bp", 16'd144, 20'h00144, 3'd3);
      step();

      // Reset on the 7th SHIFT cycle aborts the conversion
      in_data  = 16'd6765;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
      chk("abort_bcd", bcd_out, 20'h00000);
      chk("abort_nd", num_digits, 3'd1);
      early = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid) early = 1'b1;
         step();
      end
      chk("abort_no_result", early, 1'b0);

      // Calculator results for input_s = 1, 2, 10, 24
      do_conv("fib1", 16'd1, 20'h00001, 3'd1);
      step();
      do_conv("fib2", 16'd1, 20'h00001, 3'd1);
      step();
      do_conv("fib10", 16'd55, 20'h00055, 3'd2);
      step();
      do_conv("fib24", 16'd46368, 20'h46368, 3'd5);
      step();
      chk("end_idle", in_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fib_bcd_converter.md
Name: fib_bcd_converter

Overview:
Downstream stage of the Fibonacci calculator. It captures the 16-bit Fibonacci result and converts it to 5 packed BCD digits with a sequential shift-add-3 (double-dabble) engine. It presents the result over a valid/ready handshake to the display/UART formatting logic. One conversion is in flight at a time, and the result is held until consumed.

Parameters:
BIN_W, 16, binary input width; the fixed BCD_DIGITS constant covers values up to 2^16-1.
BCD_DIGITS, 5, number of output decimal digits; comes from the package and is not overridden per instance.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  binary value available; the top level drives it with the one-cycle rising edge of calculator done.
in_data  input  16  binary value, i.e. the calculator fibo_out.
in_ready  output  1  converter can accept a value.
out_valid  output  1  BCD result valid.
out_ready  input  1  consumer accepts the result.
bcd_out  output  20  packed BCD; digit 4 is in [19:16], digit 0 is in [3:0].
num_digits  output  3  count of significant digits, range 1..5; a value of 0 reports 1.

Behaviour:
- Reset:
  - Synchronous; wins over all other activity in the same cycle.
  - state=IDLE, in_ready=1, out_valid=0, bcd_out=0, num_digits=1, internal shift/count registers cleared.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load the binary shift register with in_data, clear the BCD accumulator, load bit counter=15, go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle, first every BCD nibble >=5 gets +3 (nibbles evaluated independently and in parallel).
  - Then {bcd,bin} shifts left by 1, and the bin MSB enters bcd bit 0.
  - The counter decrements; the shift with counter==0 is the 16th and final one, and the state goes to HOLD.
- HOLD:
  - out_valid=1; bcd_out and num_digits are registered and stable for the whole of HOLD.
  - num_digits = 1 + index of the highest nonzero digit, with a minimum of 1; computed in the last SHIFT cycle and registered.
  - On out_valid&&out_ready: go to IDLE; in_ready rises the next cycle (no same-cycle bypass).
  - bcd_out keeps its last value until the next conversion completes.
- Latency: accept at edge E; out_valid is high after edge E+16. Throughput is one result per 18 cycles with out_ready tied high.
- Boundary conditions:
  - in_valid while not in IDLE: ignored, no queuing.
  - in_data=0 gives bcd 0x00000 with num_digits=1.
  - 65535 gives 0x65535 with num_digits=5.
  - Nibble adjust never overflows because of the 5-digit width.
  - Reset mid-SHIFT or in HOLD: conversion aborted, no output is produced.
  - out_ready while not in HOLD: ignored.
- States: IDLE, SHIFT, HOLD. An unreachable encoding returns to IDLE.

Optional Feature:
Macro FIB_BCD_SEVENSEG_EN.
- Defined:
  - Adds output seg_out[34:0], five 7-bit groups in order {g,f,e,d,c,b,a}, active-high; group k sits in [7k+6:7k].
  - The groups are registered alongside bcd_out and valid under the same out_valid rules.
  - Leading-zero blanking: digit k with k>=num_digits drives 7'b0000000.
  - Digit 0 is never blanked.
  - Reset value is all groups blank except digit 0, which shows "0" (7'b0111111).
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fib_pkg:
  - BIN_W=16 and BCD_DIGITS=5.
  - typedef enum logic [1:0] {BCD_IDLE, BCD_SHIFT, BCD_HOLD} bcd_state_t.
  - typedef logic [3:0] bcd_digit_t.
  - 7-segment pattern constants SEG_0..SEG_9 and SEG_BLANK.
- Sub-module bcd_digit_adj: combinational per-nibble add-3-if->=5. Instantiated BCD_DIGITS times via generate.
- The 7-segment decode is a function in fib_pkg, used only under the macro.

Test Plan:
- Reset, then in_data=46368 (F24) pulsed with in_valid, out_ready=1 -> out_valid exactly 16 cycles after accept; bcd_out=0x46368, num_digits=5; in_ready high 1 cycle after transfer.
- in_data=0, then 65535 -> 0x00000/num_digits=1, then 0x65535/num_digits=5; with macro defined, seg_out for 0 is digits 4..1 blank and digit 0 = 7'b0111111.
- in_data=89, out_ready held low 10 cycles while in_valid pulses with 144 -> bcd_out=0x00089 and num_digits=2 stable throughout; 144 ignored; after out_ready, the next accepted value converts normally.
- Accept 6765, assert reset on the 7th SHIFT cycle -> next cycle out_valid=0, in_ready=1, bcd_out=0, and no result is ever emitted for 6765.
- Chain with fibonacci_calculator for input_s=1,2,10,24 -> results 0x00001, 0x00001, 0x00055, 0x46368 in order, num_digits 1,1,2,5.
